encode_opnd_bytes: RTL and testbench



---
 rtl/encode_opnd_bytes.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_encode_opnd_bytes.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/encode_opnd_bytes.sv
// ---------------------------------------------------------------------------
// encode_opnd_bytes
//
// Operand-byte serializer for the x86 encode path. One request carrying the
// ModR/M, SIB, displacement and immediate fields (with their presence and
// length flags) is captured in IDLE and replayed as a valid/ready byte stream
// in architectural order: ModR/M, SIB, displacement (little-endian),
// immediate (little-endian). A one-cycle FIN state reports completion.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid / req_ready request handshake (ready only in IDLE)
//   has_modrm, modrm      ModR/M presence flag and byte
//   has_sib, sib          SIB presence flag and byte
//   disp_len, disp        displacement byte count and value
//   imm_len, imm          immediate byte count and value
//   out_valid / out_ready output byte handshake
//   out_byte, out_last    current byte, final-byte marker
//   done, total_len       completion pulse and byte count of the request
//   err                   illegal-request pulse (coincides with done)
//
// Configuration:
//   ENCODE_OPND_CHECK_EN  when defined, requests with a disp_len outside
//                         {0,1,4}, an imm_len outside {0,1,2,4}, or a SIB
//                         without ModR/M go straight to FIN with err=1 and
//                         emit no bytes. When undefined, err is tied low
//                         and lengths 5..7 are treated as 4.
// ---------------------------------------------------------------------------
module encode_opnd_bytes (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        has_modrm,
  input  logic [7:0]  modrm,
  input  logic        has_sib,
  input  logic [7:0]  sib,
  input  logic [2:0]  disp_len,
  input  logic [31:0] disp,
  input  logic [2:0]  imm_len,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        done,
  output logic [3:0]  total_len,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MODRM = 3'd1,
    S_SIB   = 3'd2,
    S_DISP  = 3'd3,
    S_IMM   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Lengths above 4 saturate to 4 so the byte index never leaves the field.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'd4) ? 3'd4 : len;
  endfunction

  // First present field in architectural order; FIN when none remain.
  function automatic state_t first_field(input logic m, input logic s,
                                         input logic d, input logic i);
    if (m)      return S_MODRM;
    else if (s) return S_SIB;
    else if (d) return S_DISP;
    else if (i) return S_IMM;
    else        return S_FIN;
  endfunction

  // Little-endian byte k of a 32-bit field.
  function automatic logic [7:0] byte_of(input logic [31:0] f, input logic [2:0] k);
    case (k)
      3'd0:    return f[7:0];
      3'd1:    return f[15:8];
      3'd2:    return f[23:16];
      default: return f[31:24];
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        has_sib_q, has_sib_d;
  logic [7:0]  modrm_q, modrm_d;
  logic [7:0]  sib_q, sib_d;
  logic [2:0]  dlen_q, dlen_d;
  logic [31:0] disp_q, disp_d;
  logic [2:0]  ilen_q, ilen_d;
  logic [31:0] imm_q, imm_d;

  logic        req_ready_q, req_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;
  logic [3:0]  total_len_q, total_len_d;

  logic        accept_s;
  logic        hs_s;
  logic        illegal_s;

  assign accept_s = req_valid && (state_q == S_IDLE);
  assign hs_s     = out_valid_q && out_ready;

`ifdef ENCODE_OPND_CHECK_EN
  logic err_q, err_d;

  // Legality of the request currently offered on the inputs.
  always_comb begin
    illegal_s = 1'b0;
    if (!((disp_len == 3'd0) || (disp_len == 3'd1) || (disp_len == 3'd4))) begin
      illegal_s = 1'b1;
    end else if (!((imm_len == 3'd0) || (imm_len == 3'd1) ||
                   (imm_len == 3'd2) || (imm_len == 3'd4))) begin
      illegal_s = 1'b1;
    end else if (has_sib && !has_modrm) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end

  // err is only raised for a request rejected at accept, so it lands in FIN.
  always_comb begin
    err_d = accept_s && illegal_s;
  end

  // Error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign illegal_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      has_sib_q   <= 1'b0;
      modrm_q     <= 8'd0;
      sib_q       <= 8'd0;
      dlen_q      <= 3'd0;
      disp_q      <= 32'd0;
      ilen_q      <= 3'd0;
      imm_q       <= 32'd0;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'd0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      total_len_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      has_sib_q   <= has_sib_d;
      modrm_q     <= modrm_d;
      sib_q       <= sib_d;
      dlen_q      <= dlen_d;
      disp_q      <= disp_d;
      ilen_q      <= ilen_d;
      imm_q       <= imm_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      total_len_q <= total_len_d;
    end
  end

  // Next state, byte index, byte counter and request capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    has_sib_d = has_sib_q;
    modrm_d   = modrm_q;
    sib_d     = sib_q;
    dlen_d    = dlen_q;
    disp_d    = disp_q;
    ilen_d    = ilen_q;
    imm_d     = imm_q;

    if (accept_s) begin
      has_sib_d = has_sib;
      modrm_d   = modrm;
      sib_d     = sib;
      dlen_d    = clamp_len(disp_len);
      disp_d    = disp;
      ilen_d    = clamp_len(imm_len);
      imm_d     = imm;
    end else begin
      has_sib_d = has_sib_q;
    end

    if (state_q == S_FIN) begin
      cnt_d = 4'd0;
    end else if (hs_s) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
        if (accept_s) begin
          if (illegal_s) begin
            state_d = S_FIN;
          end else begin
            state_d = first_field(has_modrm, has_sib,
                                  clamp_len(disp_len) != 3'd0,
                                  clamp_len(imm_len) != 3'd0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MODRM: begin
        if (hs_s) begin
          state_d = first_field(1'b0, has_sib_q, dlen_q != 3'd0, ilen_q != 3'd0);
          idx_d   = 3'd0;
        end else begin
          state_d = S_MODRM;
        end
      end
      S_SIB: begin
        if (hs_s) begin
          state_d = first_field(1'b0, 1'b0, dlen_q != 3'd0, ilen_q != 3'd0);
          idx_d   = 3'd0;
        end else begin
          state_d = S_SIB;
        end
      end
      S_DISP: begin
        if (hs_s && (idx_q == dlen_q - 3'd1)) begin
          state_d = first_field(1'b0, 1'b0, 1'b0, ilen_q != 3'd0);
          idx_d   = 3'd0;
        end else if (hs_s) begin
          idx_d = idx_q + 3'd1;
        end else begin
          state_d = S_DISP;
        end
      end
      S_IMM: begin
        if (hs_s && (idx_q == ilen_q - 3'd1)) begin
          state_d = S_FIN;
          idx_d   = 3'd0;
        end else if (hs_s) begin
          idx_d = idx_q + 3'd1;
        end else begin
          state_d = S_IMM;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output is a register. A stalled state/index reproduces the same
  // byte, which keeps out_byte/out_last stable under backpressure.
  always_comb begin
    out_valid_d = 1'b0;
    out_byte_d  = 8'd0;
    out_last_d  = 1'b0;
    case (state_d)
      S_MODRM: begin
        out_valid_d = 1'b1;
        out_byte_d  = modrm_d;
        out_last_d  = !has_sib_d && (dlen_d == 3'd0) && (ilen_d == 3'd0);
      end
      S_SIB: begin
        out_valid_d = 1'b1;
        out_byte_d  = sib_d;
        out_last_d  = (dlen_d == 3'd0) && (ilen_d == 3'd0);
      end
      S_DISP: begin
        out_valid_d = 1'b1;
        out_byte_d  = byte_of(disp_d, idx_d);
        out_last_d  = (idx_d == dlen_d - 3'd1) && (ilen_d == 3'd0);
      end
      S_IMM: begin
        out_valid_d = 1'b1;
        out_byte_d  = byte_of(imm_d, idx_d);
        out_last_d  = (idx_d == ilen_d - 3'd1);
      end
      default: begin
        out_valid_d = 1'b0;
        out_byte_d  = 8'd0;
        out_last_d  = 1'b0;
      end
    endcase
    done_d      = (state_d == S_FIN);
    total_len_d = (state_d == S_FIN) ? cnt_d : 4'd0;
    req_ready_d = (state_d == S_IDLE);
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign total_len = total_len_q;

endmodule

// File: tb/tb_encode_opnd_bytes.sv
module tb_encode_opnd_bytes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        has_modrm;
  logic [7:0]  modrm;
  logic        has_sib;
  logic [7:0]  sib;
  logic [2:0]  disp_len;
  logic [31:0] disp;
  logic [2:0]  imm_len;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        done;
  logic [3:0]  total_len;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // Results gathered by the collector for the current request.
  int          c_n;
  logic [7:0]  c_bytes [16];
  int          c_hs_cyc [16];
  logic [15:0] c_last_mask;
  int          c_done_cyc;
  logic [3:0]  c_total;
  logic        c_err;
  int          c_valid_cycles;
  int          c_stall_viol;
  int          c_ready_viol;

  always #5 clk = ~clk;

  encode_opnd_bytes dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .has_modrm(has_modrm), .modrm(modrm),
    .has_sib(has_sib), .sib(sib),
    .disp_len(disp_len), .disp(disp),
    .imm_len(imm_len), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last),
    .done(done), .total_len(total_len), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic junk_fields();
    has_modrm = 1'b1; modrm = 8'hFF; has_sib = 1'b1; sib = 8'hEE;
    disp_len = 3'd7; disp = 32'hDEADBEEF; imm_len = 3'd7; imm = 32'hCAFEF00D;
  endtask

  // Present one request at a negedge; returns at the first negedge after accept.
  task automatic send(input logic m_en, input logic [7:0] m, input logic s_en,
                      input logic [7:0] s, input logic [2:0] dl, input logic [31:0] d,
                      input logic [2:0] il, input logic [31:0] i);
    @(negedge clk);
    has_modrm = m_en; modrm = m; has_sib = s_en; sib = s;
    disp_len = dl; disp = d; imm_len = il; imm = i;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    junk_fields();
  endtask

  // Sample the output stream once per negedge until done or budget expiry.
  task automatic collect(input bit toggle, input int budget);
    logic [7:0] held_b;
    logic       held_l;
    bit         stalled;
    c_n = 0; c_last_mask = 16'd0; c_done_cyc = -1; c_total = 4'd0; c_err = 1'b0;
    c_valid_cycles = 0; c_stall_viol = 0; c_ready_viol = 0;
    stalled = 1'b0; held_b = 8'd0; held_l = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled && (!out_valid || out_byte !== held_b || out_last !== held_l))
        c_stall_viol++;
      stalled = 1'b0;
      if (req_ready) c_ready_viol++;
      if (out_valid) begin
        c_valid_cycles++;
        if (out_ready) begin
          if (c_n < 16) begin
            c_bytes[c_n] = out_byte;
            c_hs_cyc[c_n] = cyc;
            if (out_last) c_last_mask[c_n] = 1'b1;
          end
          c_n++;
        end else begin
          stalled = 1'b1; held_b = out_byte; held_l = out_last;
        end
      end
      if (done) begin
        c_done_cyc = cyc; c_total = total_len; c_err = err;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    has_modrm = 1'b0; modrm = 8'd0; has_sib = 1'b0; sib = 8'd0;
    disp_len = 3'd0; disp = 32'd0; imm_len = 3'd0; imm = 32'd0;
    repeat (3) @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_tests++; if ({out_valid, out_byte, out_last} !== 10'd0) begin n_fail++; $display("FAIL reset_out got v=%b b=%h l=%b exp 0", out_valid, out_byte, out_last); end
    n_tests++; if ({done, total_len, err} !== 6'd0) begin n_fail++; $display("FAIL reset_status got d=%b t=%0d e=%b exp 0", done, total_len, err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got rdy=%b v=%b exp 1/0", req_ready, out_valid); end
  endtask

  task automatic test_full();
    logic [7:0] exp_b [7];
    exp_b = '{8'h84, 8'h24, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAB};
    send(1'b1, 8'h84, 1'b1, 8'h24, 3'd4, 32'h12345678, 3'd1, 32'h000000AB);
    collect(1'b0, 40);
    n_tests++; if (c_n !== 7) begin n_fail++; $display("FAIL full_count got %0d exp 7", c_n); end
    for (int k = 0; k < 7; k++) begin
      n_tests++; if (c_bytes[k] !== exp_b[k]) begin n_fail++; $display("FAIL full_byte%0d got %h exp %h", k, c_bytes[k], exp_b[k]); end
    end
    n_tests++; if (c_hs_cyc[0] !== 0 || c_hs_cyc[6] !== 6) begin n_fail++; $display("FAIL full_timing got first=%0d last=%0d exp 0/6", c_hs_cyc[0], c_hs_cyc[6]); end
    n_tests++; if (c_last_mask !== 16'h0040) begin n_fail++; $display("FAIL full_last got %h exp 0040", c_last_mask); end
    n_tests++; if (c_done_cyc !== 7 || c_total !== 4'd7) begin n_fail++; $display("FAIL full_done got cyc=%0d len=%0d exp 7/7", c_done_cyc, c_total); end
    n_tests++; if (c_ready_viol !== 0) begin n_fail++; $display("FAIL full_req_ready_low got %0d high cycles exp 0", c_ready_viol); end
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_return got %b exp 1", req_ready); end
  endtask

  task automatic test_stall();
    send(1'b1, 8'hC0, 1'b0, 8'h00, 3'd0, 32'd0, 3'd2, 32'h0000BEEF);
    collect(1'b1, 40);
    n_tests++; if (c_n !== 3) begin n_fail++; $display("FAIL stall_count got %0d exp 3", c_n); end
    n_tests++; if ({c_bytes[0], c_bytes[1], c_bytes[2]} !== 24'hC0EFBE) begin n_fail++; $display("FAIL stall_bytes got %h%h%h exp c0efbe", c_bytes[0], c_bytes[1], c_bytes[2]); end
    n_tests++; if (c_hs_cyc[1] !== 2 || c_hs_cyc[2] !== 4) begin n_fail++; $display("FAIL stall_timing got %0d/%0d exp 2/4", c_hs_cyc[1], c_hs_cyc[2]); end
    n_tests++; if (c_stall_viol !== 0) begin n_fail++; $display("FAIL stall_stable got %0d changes exp 0", c_stall_viol); end
    n_tests++; if (c_last_mask !== 16'h0004) begin n_fail++; $display("FAIL stall_last got %h exp 0004", c_last_mask); end
    n_tests++; if (c_done_cyc !== 5 || c_total !== 4'd3) begin n_fail++; $display("FAIL stall_done got cyc=%0d len=%0d exp 5/3", c_done_cyc, c_total); end
  endtask

  task automatic test_zero();
    send(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 32'd0, 3'd0, 32'd0);
    collect(1'b0, 10);
    n_tests++; if (c_valid_cycles !== 0) begin n_fail++; $display("FAIL zero_no_valid got %0d exp 0", c_valid_cycles); end
    n_tests++; if (c_done_cyc !== 0 || c_total !== 4'd0 || c_err !== 1'b0) begin n_fail++; $display("FAIL zero_done got cyc=%0d len=%0d err=%b exp 0/0/0", c_done_cyc, c_total, c_err); end
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_ready got rdy=%b done=%b exp 1/0", req_ready, done); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    send(1'b1, 8'h8B, 1'b0, 8'h00, 3'd4, 32'hDDCCBBAA, 3'd1, 32'h00000055);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || out_byte !== 8'hBB) begin n_fail++; $display("FAIL mid_third_byte got v=%b b=%h exp 1/bb", out_valid, out_byte); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({out_valid, out_byte, out_last, done, total_len, err} !== 15'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_outputs got v=%b b=%h l=%b d=%b t=%0d e=%b r=%b exp zeros/r=1", out_valid, out_byte, out_last, done, total_len, err, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || out_valid) done_seen++;
    end
    n_tests++; if (done_seen !== 0) begin n_fail++; $display("FAIL mid_no_done got %0d active cycles exp 0", done_seen); end
    send(1'b0, 8'h00, 1'b0, 8'h00, 3'd1, 32'h0000007F, 3'd0, 32'd0);
    collect(1'b0, 10);
    n_tests++; if (c_n !== 1 || c_bytes[0] !== 8'h7F || c_last_mask !== 16'h0001) begin n_fail++; $display("FAIL mid_after_byte got n=%0d b=%h last=%h exp 1/7f/0001", c_n, c_bytes[0], c_last_mask); end
    n_tests++; if (c_total !== 4'd1 || c_done_cyc !== 1) begin n_fail++; $display("FAIL mid_after_done got len=%0d cyc=%0d exp 1/1", c_total, c_done_cyc); end
  endtask

  task automatic test_disp2();
    send(1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 32'h00001234, 3'd0, 32'd0);
    collect(1'b0, 20);
`ifdef ENCODE_OPND_CHECK_EN
    n_tests++; if (c_valid_cycles !== 0) begin n_fail++; $display("FAIL disp2_no_bytes got %0d exp 0", c_valid_cycles); end
    n_tests++; if (c_err !== 1'b1 || c_done_cyc !== 0 || c_total !== 4'd0) begin n_fail++; $display("FAIL disp2_err got err=%b cyc=%0d len=%0d exp 1/0/0", c_err, c_done_cyc, c_total); end
`else
    n_tests++; if (c_n !== 2 || c_bytes[0] !== 8'h34 || c_bytes[1] !== 8'h12) begin n_fail++; $display("FAIL disp2_bytes got n=%0d %h %h exp 2/34/12", c_n, c_bytes[0], c_bytes[1]); end
    n_tests++; if (c_total !== 4'd2 || c_err !== 1'b0 || c_last_mask !== 16'h0002) begin n_fail++; $display("FAIL disp2_done got len=%0d err=%b last=%h exp 2/0/0002", c_total, c_err, c_last_mask); end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    has_modrm = 1'b1; modrm = 8'h11; has_sib = 1'b0; sib = 8'h00;
    disp_len = 3'd0; disp = 32'd0; imm_len = 3'd1; imm = 32'h00000022;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Second request offered while the first is still being emitted.
    has_modrm = 1'b1; modrm = 8'h33; has_sib = 1'b1; sib = 8'h44;
    disp_len = 3'd0; disp = 32'd0; imm_len = 3'd0; imm = 32'd0;
    collect(1'b0, 20);
    n_tests++; if (c_n !== 2 || c_bytes[0] !== 8'h11 || c_bytes[1] !== 8'h22) begin n_fail++; $display("FAIL b2b_first got n=%0d %h %h exp 2/11/22", c_n, c_bytes[0], c_bytes[1]); end
    n_tests++; if (c_total !== 4'd2 || c_ready_viol !== 0) begin n_fail++; $display("FAIL b2b_first_done got len=%0d rdy_hi=%0d exp 2/0", c_total, c_ready_viol); end
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    junk_fields();
    collect(1'b0, 20);
    n_tests++; if (c_n !== 2 || c_bytes[0] !== 8'h33 || c_bytes[1] !== 8'h44) begin n_fail++; $display("FAIL b2b_second got n=%0d %h %h exp 2/33/44", c_n, c_bytes[0], c_bytes[1]); end
    n_tests++; if (c_total !== 4'd2 || c_last_mask !== 16'h0002) begin n_fail++; $display("FAIL b2b_second_done got len=%0d last=%h exp 2/0002", c_total, c_last_mask); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_stall();
    test_zero();
    test_reset_mid();
    test_disp2();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
